// File: rtl/pc_sequencer.sv
// MIPS-I program-counter sequencer: owns the FETCH/EXEC phase, resolves branches and
// jumps from register operands, and handles delay slot, link, halt and misaligned targets.
module pc_sequencer #(
    parameter int unsigned ADDR_W       = 32,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000,
    parameter bit          DELAY_SLOT   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [31:0]       instruction_word,
    input  logic [31:0]       read_data_0,
    input  logic [31:0]       read_data_1,
    output logic              state,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] link_addr,
    output logic              link_en,
    output logic [4:0]        link_reg,
    output logic              finish,
    output logic              addr_err
);

    localparam logic [ADDR_W-1:0] RESET_PC = RESET_VECTOR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] HALT_PC  = HALT_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] PC_EIGHT = ADDR_W'(8);

    typedef enum logic [1:0] {
        PH_FETCH = 2'd0,
        PH_EXEC  = 2'd1,
        PH_HALT  = 2'd2
    } phase_e;

    phase_e            phase_q, phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              pending_q, pending_d;
    logic              finish_q, finish_d;
    logic              addr_err_q, addr_err_d;

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        rt_sel;
    logic              is_branch;
    logic              branch_cond;
    logic              is_jump;
    logic              is_jreg;
    logic              link_req;
    logic [4:0]        link_dst;
    logic              rs_neg;
    logic              rs_zero;

    logic [31:0]       addr_ext;
    logic [31:0]       pc4_ext;
    logic [31:0]       branch_off;
    logic [31:0]       target_ext;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] xfer_target;
    logic              xfer_taken;
    logic              misaligned;

    assign op      = instruction_word[31:26];
    assign funct   = instruction_word[5:0];
    assign rt_sel  = instruction_word[20:16];
    assign rs_neg  = read_data_0[31];
    assign rs_zero = (read_data_0 == 32'd0);

    always_comb begin
        is_branch   = 1'b0;
        branch_cond = 1'b0;
        is_jump     = 1'b0;
        is_jreg     = 1'b0;
        link_req    = 1'b0;
        link_dst    = 5'd31;
        case (op)
            6'h04: begin
                is_branch   = 1'b1;
                branch_cond = (read_data_0 == read_data_1);
            end
            6'h05: begin
                is_branch   = 1'b1;
                branch_cond = (read_data_0 != read_data_1);
            end
            6'h06: begin
                is_branch   = 1'b1;
                branch_cond = rs_neg || rs_zero;
            end
            6'h07: begin
                is_branch   = 1'b1;
                branch_cond = !rs_neg && !rs_zero;
            end
            6'h01: begin
                // The AL variants link regardless of the branch outcome.
                case (rt_sel)
                    5'h00: begin
                        is_branch   = 1'b1;
                        branch_cond = rs_neg;
                    end
                    5'h01: begin
                        is_branch   = 1'b1;
                        branch_cond = !rs_neg;
                    end
                    5'h10: begin
                        is_branch   = 1'b1;
                        branch_cond = rs_neg;
                        link_req    = 1'b1;
                    end
                    5'h11: begin
                        is_branch   = 1'b1;
                        branch_cond = !rs_neg;
                        link_req    = 1'b1;
                    end
                    default: ;
                endcase
            end
            6'h02: is_jump = 1'b1;
            6'h03: begin
                is_jump  = 1'b1;
                link_req = 1'b1;
            end
            6'h00: begin
                if (funct == 6'h08) begin
                    is_jreg = 1'b1;
                end else if (funct == 6'h09) begin
                    is_jreg  = 1'b1;
                    link_req = 1'b1;
                    link_dst = instruction_word[15:11];
                end
            end
            default: ;
        endcase
    end

    // Targets are formed at 32 bits from the zero-extended PC, then truncated.
    always_comb begin
        addr_ext               = 32'd0;
        addr_ext[ADDR_W-1:0]   = addr_q;
    end

    assign pc4_ext    = addr_ext + 32'd4;
    assign branch_off = {{14{instruction_word[15]}}, instruction_word[15:0], 2'b00};

    always_comb begin
        if (is_jreg) begin
            target_ext = read_data_0;
        end else if (is_jump) begin
            target_ext = {pc4_ext[31:28], instruction_word[25:0], 2'b00};
        end else begin
            target_ext = pc4_ext + branch_off;
        end
    end

    assign pc_plus4    = pc4_ext[ADDR_W-1:0];
    assign xfer_target = target_ext[ADDR_W-1:0];
    assign xfer_taken  = !pending_q && (is_jump || is_jreg || (is_branch && branch_cond));
    assign misaligned  = !pending_q && is_jreg && (read_data_0[1:0] != 2'b00);

    always_comb begin
        phase_d    = phase_q;
        addr_d     = addr_q;
        target_d   = target_q;
        pending_d  = pending_q;
        finish_d   = finish_q;
        addr_err_d = addr_err_q;
        case (phase_q)
            PH_FETCH: begin
                if (!stall) begin
                    phase_d = PH_EXEC;
                end
            end
            PH_EXEC: begin
                if (!stall) begin
                    phase_d = PH_FETCH;
                    if (pending_q) begin
                        addr_d    = target_q;
                        pending_d = 1'b0;
                        if (target_q == HALT_PC) begin
                            phase_d  = PH_HALT;
                            finish_d = 1'b1;
                        end
                    end else if (misaligned) begin
                        addr_d     = pc_plus4;
                        addr_err_d = 1'b1;
                        phase_d    = PH_HALT;
                    end else if (xfer_taken && DELAY_SLOT) begin
                        addr_d    = pc_plus4;
                        target_d  = xfer_target;
                        pending_d = 1'b1;
                    end else if (xfer_taken) begin
                        addr_d = xfer_target;
                        if (xfer_target == HALT_PC) begin
                            phase_d  = PH_HALT;
                            finish_d = 1'b1;
                        end
                    end else begin
                        addr_d = pc_plus4;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q    <= PH_FETCH;
            addr_q     <= RESET_PC;
            target_q   <= '0;
            pending_q  <= 1'b0;
            finish_q   <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            addr_q     <= addr_d;
            target_q   <= target_d;
            pending_q  <= pending_d;
            finish_q   <= finish_d;
            addr_err_q <= addr_err_d;
        end
    end

    // A delay-slot instruction is treated as a non-branch, so it never links.
    assign state     = (phase_q == PH_EXEC);
    assign addr      = addr_q;
    assign link_addr = addr_q + PC_EIGHT;
    assign link_en   = (phase_q == PH_EXEC) && !pending_q && link_req;
    assign link_reg  = link_en ? link_dst : 5'd0;
    assign finish    = finish_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: two instances (with and without delay slot) are
// driven in lockstep and compared every cycle against a behavioural reference model.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] instruction_word;
    logic [31:0] read_data_0;
    logic [31:0] read_data_1;

    logic        state_o     [2];
    logic [31:0] addr_o      [2];
    logic [31:0] link_addr_o [2];
    logic        link_en_o   [2];
    logic [4:0]  link_reg_o  [2];
    logic        finish_o    [2];
    logic        addr_err_o  [2];

    int checks = 0;
    int errors = 0;

    // Reference model state: phase 0 = fetch, 1 = exec, 2 = halted.
    int          m_ph   [2];
    logic [31:0] m_pc   [2];
    logic [31:0] m_tgt  [2];
    bit          m_pend [2];
    bit          m_fin  [2];
    bit          m_err  [2];

    pc_sequencer #(.DELAY_SLOT(1'b1)) dut_ds (
        .clk(clk), .reset(reset), .stall(stall),
        .instruction_word(instruction_word),
        .read_data_0(read_data_0), .read_data_1(read_data_1),
        .state(state_o[0]), .addr(addr_o[0]), .link_addr(link_addr_o[0]),
        .link_en(link_en_o[0]), .link_reg(link_reg_o[0]),
        .finish(finish_o[0]), .addr_err(addr_err_o[0])
    );

    pc_sequencer #(.DELAY_SLOT(1'b0)) dut_nods (
        .clk(clk), .reset(reset), .stall(stall),
        .instruction_word(instruction_word),
        .read_data_0(read_data_0), .read_data_1(read_data_1),
        .state(state_o[1]), .addr(addr_o[1]), .link_addr(link_addr_o[1]),
        .link_en(link_en_o[1]), .link_reg(link_reg_o[1]),
        .finish(finish_o[1]), .addr_err(addr_err_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Architectural meaning of one instruction at a given PC.
    function automatic void refDecode(input logic [31:0] iw, input logic [31:0] rs, input logic [31:0] rt,
                                      input logic [31:0] pc, output bit xfer, output bit jr,
                                      output logic [31:0] tgt, output bit lnk, output logic [4:0] lreg);
        int op;
        int sel;
        int fn;
        int signed srs;
        int signed off;
        op   = int'(iw[31:26]);
        sel  = int'(iw[20:16]);
        fn   = int'(iw[5:0]);
        srs  = $signed(rs);
        off  = $signed(iw[15:0]);
        xfer = 0;
        jr   = 0;
        lnk  = 0;
        lreg = 5'd0;
        tgt  = pc + 32'd4 + 32'(off * 4);
        case (op)
            4: xfer = (rs == rt);
            5: xfer = (rs != rt);
            6: xfer = (srs <= 0);
            7: xfer = (srs > 0);
            1: begin
                case (sel)
                    0:  xfer = (srs < 0);
                    1:  xfer = (srs >= 0);
                    16: begin xfer = (srs < 0);  lnk = 1; lreg = 5'd31; end
                    17: begin xfer = (srs >= 0); lnk = 1; lreg = 5'd31; end
                    default: ;
                endcase
            end
            2, 3: begin
                xfer = 1;
                tgt  = ((pc + 32'd4) & 32'hF000_0000) | (32'(iw[25:0]) * 32'd4);
                if (op == 3) begin
                    lnk  = 1;
                    lreg = 5'd31;
                end
            end
            0: begin
                if (fn == 8 || fn == 9) begin
                    xfer = 1;
                    jr   = 1;
                    tgt  = rs;
                    if (fn == 9) begin
                        lnk  = 1;
                        lreg = iw[15:11];
                    end
                end
            end
            default: ;
        endcase
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i]   = 0;
            m_pc[i]   = 32'hBFC0_0000;
            m_tgt[i]  = 32'd0;
            m_pend[i] = 0;
            m_fin[i]  = 0;
            m_err[i]  = 0;
        end
    endtask

    task automatic modelStep(input int i);
        bit          xfer;
        bit          jr;
        bit          lnk;
        logic [31:0] tgt;
        logic [4:0]  lreg;
        if (m_ph[i] == 0) begin
            if (!stall) m_ph[i] = 1;
        end else if (m_ph[i] == 1 && !stall) begin
            refDecode(instruction_word, read_data_0, read_data_1, m_pc[i], xfer, jr, tgt, lnk, lreg);
            m_ph[i] = 0;
            if (m_pend[i]) begin
                m_pc[i]   = m_tgt[i];
                m_pend[i] = 0;
                if (m_pc[i] == 32'd0) begin m_ph[i] = 2; m_fin[i] = 1; end
            end else if (jr && read_data_0[1:0] != 2'b00) begin
                m_err[i] = 1;
                m_ph[i]  = 2;
                m_pc[i]  = m_pc[i] + 32'd4;
            end else if (xfer && i == 0) begin
                m_tgt[i]  = tgt;
                m_pend[i] = 1;
                m_pc[i]   = m_pc[i] + 32'd4;
            end else if (xfer) begin
                m_pc[i] = tgt;
                if (tgt == 32'd0) begin m_ph[i] = 2; m_fin[i] = 1; end
            end else begin
                m_pc[i] = m_pc[i] + 32'd4;
            end
        end
    endtask

    task automatic checkAll();
        bit          xfer;
        bit          jr;
        bit          lnk;
        bit          exp_le;
        logic [31:0] tgt;
        logic [4:0]  lreg;
        for (int i = 0; i < 2; i++) begin
            refDecode(instruction_word, read_data_0, read_data_1, m_pc[i], xfer, jr, tgt, lnk, lreg);
            exp_le = (m_ph[i] == 1) && !m_pend[i] && lnk;
            checkOutput($sformatf("state%0d", i),     32'(state_o[i]),    32'(m_ph[i] == 1));
            checkOutput($sformatf("addr%0d", i),      addr_o[i],          m_pc[i]);
            checkOutput($sformatf("link_addr%0d", i), link_addr_o[i],     m_pc[i] + 32'd8);
            checkOutput($sformatf("link_en%0d", i),   32'(link_en_o[i]),  32'(exp_le));
            checkOutput($sformatf("finish%0d", i),    32'(finish_o[i]),   32'(m_fin[i]));
            checkOutput($sformatf("addr_err%0d", i),  32'(addr_err_o[i]), 32'(m_err[i]));
            if (exp_le)
                checkOutput($sformatf("link_reg%0d", i), 32'(link_reg_o[i]), 32'(lreg));
            else if (m_ph[i] == 0)
                checkOutput($sformatf("link_reg_fetch%0d", i), 32'(link_reg_o[i]), 32'd0);
        end
    endtask

    task automatic applyStimulus(input bit st, input logic [31:0] iw, input logic [31:0] rs, input logic [31:0] rt);
        stall            = st;
        instruction_word = iw;
        read_data_0      = rs;
        read_data_1      = rt;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        for (int i = 0; i < 2; i++) modelStep(i);
        #1;
    endtask

    task automatic runCycle(input bit st, input logic [31:0] iw, input logic [31:0] rs, input logic [31:0] rt);
        applyStimulus(st, iw, rs, rt);
        @(negedge clk);
        checkAll();
        clockEdge();
    endtask

    // Reset is checked before any clock edge so its asynchronous effect is visible.
    task automatic doReset(input bit with_stall);
        reset = 1'b1;
        stall = with_stall;
        modelReset();
        #2;
        checkAll();
        @(posedge clk);
        #1;
        checkAll();
        reset = 1'b0;
        stall = 1'b0;
    endtask

    task automatic fetchThenHold(input logic [31:0] iw, input logic [31:0] rs, input logic [31:0] rt, input int nstall);
        runCycle(1'b0, $urandom(), $urandom(), $urandom());
        for (int k = 0; k < nstall; k++) runCycle(1'b1, iw, rs, rt);
        applyStimulus(1'b0, iw, rs, rt);
        @(negedge clk);
        checkAll();
    endtask

    task automatic step(input logic [31:0] iw, input logic [31:0] rs, input logic [31:0] rt, input int nstall);
        fetchThenHold(iw, rs, rt, nstall);
        clockEdge();
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    task automatic randomCycle();
        logic [31:0] iw;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  sel;
        int          r;
        bit          st;
        st = ($urandom_range(0, 4) == 0);
        rs = randOperand();
        rt = ($urandom_range(0, 2) == 0) ? rs : randOperand();
        case ($urandom_range(0, 9))
            0, 1: iw = {6'($urandom_range(8, 63)), 26'($urandom())};
            2, 3: iw = {6'($urandom_range(4, 7)), 26'($urandom())};
            4: begin
                case ($urandom_range(0, 4))
                    0:       sel = 5'h00;
                    1:       sel = 5'h01;
                    2:       sel = 5'h10;
                    3:       sel = 5'h11;
                    default: sel = 5'($urandom());
                endcase
                iw = {6'h01, 5'($urandom()), sel, 16'($urandom())};
            end
            5: iw = {6'($urandom_range(2, 3)), 26'($urandom())};
            6: begin
                iw = {6'h00, 15'($urandom()), 5'd0, ($urandom_range(0, 1) == 1) ? 6'h09 : 6'h08};
                r  = $urandom_range(0, 15);
                rs = $urandom() & 32'hFFFF_FFFC;
                if (r == 0) rs = 32'd0;
                else if (r < 4) rs = rs | 32'(r);
            end
            7: iw = {6'h00, 20'($urandom()), 6'($urandom_range(10, 63))};
            default: iw = 32'h0000_0000;
        endcase
        runCycle(st, iw, rs, rt);
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0);
        #1;
        doReset(1'b0);

        // Sequential NOPs.
        step(32'h0, 32'h0, 32'h0, 0);
        step(32'h0, 32'h0, 32'h0, 0);
        checkOutput("seq_addr", addr_o[0], 32'hBFC0_0008);

        // Taken BEQ: delay slot vs immediate.
        step(32'h1022_0002, 32'd5, 32'd5, 0);
        checkOutput("beq_slot", addr_o[0], 32'hBFC0_000C);
        checkOutput("beq_nods", addr_o[1], 32'hBFC0_0014);
        step(32'h0, 32'h0, 32'h0, 0);
        checkOutput("beq_target", addr_o[0], 32'hBFC0_0014);

        // BGEZAL not taken still links.
        fetchThenHold(32'h0411_0002, 32'hFFFF_FFFF, 32'h0, 0);
        checkOutput("bgezal_link_en", 32'(link_en_o[0]), 32'd1);
        checkOutput("bgezal_link_reg", 32'(link_reg_o[0]), 32'd31);
        checkOutput("bgezal_link_addr", link_addr_o[0], 32'hBFC0_001C);
        clockEdge();
        checkOutput("bgezal_seq", addr_o[0], 32'hBFC0_0018);

        // Taken BNE held in EXEC by stall.
        fetchThenHold(32'h1422_0003, 32'd1, 32'd2, 3);
        checkOutput("bne_stall_state", 32'(state_o[0]), 32'd1);
        checkOutput("bne_stall_addr", addr_o[0], 32'hBFC0_0018);
        clockEdge();
        checkOutput("bne_slot", addr_o[0], 32'hBFC0_001C);
        step(32'h0, 32'h0, 32'h0, 0);
        checkOutput("bne_target", addr_o[0], 32'hBFC0_0028);

        // JALR to the halt address.
        fetchThenHold(32'h0000_F809, 32'd0, 32'd0, 0);
        checkOutput("jalr_link_en", 32'(link_en_o[0]), 32'd1);
        checkOutput("jalr_link_reg", 32'(link_reg_o[0]), 32'd31);
        clockEdge();
        step(32'h0, 32'h0, 32'h0, 0);
        for (int k = 0; k < 6; k++) runCycle(k[0], 32'h0, 32'h0, 32'h0);
        checkOutput("halt_addr", addr_o[0], 32'd0);
        checkOutput("halt_finish", 32'(finish_o[0]), 32'd1);
        checkOutput("halt_state", 32'(state_o[0]), 32'd0);

        // Reset discards a pending delay-slot target.
        doReset(1'b0);
        step(32'h1022_0002, 32'd5, 32'd5, 0);
        doReset(1'b1);
        step(32'h0, 32'h0, 32'h0, 0);
        checkOutput("reset_discards_pending", addr_o[0], 32'hBFC0_0004);

        // Misaligned JR.
        step(32'h0000_0008, 32'h0000_0102, 32'h0, 0);
        checkOutput("misalign_err", 32'(addr_err_o[0]), 32'd1);
        checkOutput("misalign_finish", 32'(finish_o[0]), 32'd0);
        checkOutput("misalign_addr", addr_o[0], 32'hBFC0_0008);
        runCycle(1'b0, 32'h0, 32'h0, 32'h0);
        doReset(1'b0);
        checkOutput("misalign_cleared", 32'(addr_err_o[0]), 32'd0);
        checkOutput("misalign_reset_addr", addr_o[0], 32'hBFC0_0000);

        $display("[TB] directed phase done, starting random episodes");
        for (int ep = 0; ep < 30; ep++) begin
            doReset($urandom_range(0, 1) == 1);
            for (int c = 0; c < 40; c++) randomCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised successor to the existing MIPS program-counter block. It owns the fetch/execute phase state machine internally instead of receiving it as an input. It evaluates all MIPS-I branch conditions itself from the register operands instead of from external N/Z/EQ flags. It supports an optional branch delay slot, link generation, halt detection and misaligned-jump detection. It sits between the register file and the memory-address mux in the multicycle CPU.

Parameters:
ADDR_W, 32, PC width (16..32); all address arithmetic is modulo 2^ADDR_W.
RESET_VECTOR, 32'hBFC00000, PC value after reset (truncated to ADDR_W).
HALT_ADDR, 32'h00000000, a control-transfer target equal to this halts the core.
DELAY_SLOT, 1, 1 = MIPS branch delay slot; 0 = transfer takes effect immediately.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
stall  in  1  freezes phase, PC and pending-target registers.
instruction_word  in  32  instruction; valid during EXEC.
read_data_0  in  32  rs value.
read_data_1  in  32  rt value.
state  out  1  phase: 0 = FETCH, 1 = EXEC.
addr  out  ADDR_W  current PC.
link_addr  out  ADDR_W  addr+8, combinational.
link_en  out  1  request to write link_addr to link_reg this EXEC.
link_reg  out  5  link destination.
finish  out  1  sticky halt indication.
addr_err  out  1  sticky misaligned-target error.

Behaviour:
- Reset (async): FSM = FETCH, addr = RESET_VECTOR, pending = 0, target_q = 0, finish = 0, addr_err = 0. link_en and link_reg are 0 during FETCH.
- FSM states: FETCH, EXEC, HALT.
  - FETCH -> EXEC on a clock edge with !stall.
  - EXEC -> FETCH on a clock edge with !stall.
  - HALT is absorbing until reset; stall is ignored in HALT.
  - state output is 1 only in EXEC; it is 0 in both FETCH and HALT.
- PC update happens only on the EXEC->FETCH edge; addr does not change on any other edge. Priority order:
  1. pending = 1: addr <= target_q, pending <= 0. Any transfer in the delay-slot instruction is ignored and treated as a non-branch.
  2. Taken transfer with DELAY_SLOT = 1: target_q <= target, pending <= 1, addr <= addr+4.
  3. Taken transfer with DELAY_SLOT = 0: addr <= target.
  4. Otherwise: addr <= addr+4, wrapping modulo 2^ADDR_W.
- Decode. op = iw[31:26], rt = iw[20:16], funct = iw[5:0].
  - BEQ (04): taken if rs == rt.
  - BNE (05): taken if rs != rt.
  - BLEZ (06): taken if rs <= 0, signed.
  - BGTZ (07): taken if rs > 0, signed.
  - REGIMM (01), selected by rt: BLTZ 00, BGEZ 01, BLTZAL 10, BGEZAL 11.
  - J (02), JAL (03).
  - SPECIAL (00) with funct JR 08, JALR 09.
  - Anything else is a non-transfer.
- Target rules:
  - Branches: (addr+4) + (sign_ext(iw[15:0]) << 2).
  - J/JAL: {(addr+4)[31:28], iw[25:0], 2'b00} computed at 32 bits with addr zero-extended, then truncated to ADDR_W.
  - JR/JALR: read_data_0 truncated to ADDR_W.
- Link:
  - JAL, BLTZAL, BGEZAL: link_en = 1 in EXEC, link_reg = 31. BxxAL links whether or not the branch is taken.
  - JALR: link_en = 1 in EXEC, link_reg = iw[15:11].
  - link_en is suppressed in HALT.
- Halt: on the edge where addr would be loaded with HALT_ADDR (path 1, or path 3), FSM <= HALT and finish <= 1. addr takes HALT_ADDR and then holds.
- Misalign: a JR/JALR in EXEC with read_data_0[1:0] != 0 sets addr_err <= 1 and FSM <= HALT on the EXEC exit edge. addr <= addr+4 and no pending target is created. addr_err takes priority over finish.
- Stall held at any phase: all registers hold, and outputs are stable.
- Simultaneous reset and stall: reset wins.
- Reset during a pending delay slot discards the target.

Test Plan:
- Sequential: reset, then feed NOPs. addr goes 0xBFC00000 -> 0xBFC00004 -> 0xBFC00008, one step per FETCH/EXEC pair; state toggles every clock.
- BEQ taken with delay slot: at 0xBFC00008, iw = 0x10220002, rs = rt = 5. Next addr = 0xBFC0000C (the slot), then 0xBFC00014.
  - With DELAY_SLOT = 0, the next addr is 0xBFC00014 directly.
- BGEZAL not taken: iw = 0x04110002, rs = 0xFFFFFFFF. In EXEC, link_en = 1, link_reg = 31, link_addr = addr+8. The PC proceeds sequentially.
- Stall: assert stall for 3 cycles in EXEC during a taken BNE (0x14220003, rs = 1, rt = 2). state, addr and pending are unchanged throughout; after release the delay slot and target follow normally.
- Halt: JALR, iw = 0x0000F809, rs = 0. link_reg = 31, link_en = 1. After the delay slot, addr = 0, finish = 1, state held at 0 despite further clocks and stall toggling.
- Misaligned JR: iw = 0x00000008, rs = 0x00000102. addr_err = 1, finish = 0, FSM halts, addr = old addr+4. A subsequent reset clears addr_err and restores addr = 0xBFC00000.
